// File: rtl/sram_axi_master_pkg.sv
// Shared AXI3 channel widths and encodings for the SRAM-style AXI initiator.
package sram_axi_master_pkg;

  localparam int unsigned Larid   = 4;
  localparam int unsigned Laraddr = 32;
  localparam int unsigned Lrdata  = 32;
  localparam int unsigned Lwstrb  = 4;
  localparam int unsigned Llen    = 4;
  localparam int unsigned Lburst  = 2;
  localparam int unsigned Llock   = 2;
  localparam int unsigned Lcache  = 4;
  localparam int unsigned Lprot   = 3;
  localparam int unsigned Lresp   = 2;

  localparam int unsigned AXI_SIZE_W = 3;
  localparam logic [Lburst-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [Lresp-1:0]  AXI_RESP_OKAY  = 2'b00;

  // Request captured on accept; drives the AR/AW/W payloads for the whole transaction.
  typedef struct packed {
    logic [Laraddr-1:0] addr;
    logic [1:0]         size;
    logic [Lrdata-1:0]  wdata;
    logic [Lwstrb-1:0]  wstrb;
  } req_payload_t;

endpackage

// File: rtl/sram_axi_master.sv
// Simple req/addr_ok/data_ok memory port to single-beat AXI3 reads and writes,
// one transaction outstanding at a time.
module sram_axi_master
  import sram_axi_master_pkg::*;
#(
  parameter logic [Larid-1:0] ID = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [Laraddr-1:0]    addr,
  input  logic [Lrdata-1:0]     wdata,
  input  logic [Lwstrb-1:0]     wstrb,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [Lrdata-1:0]     rdata,
  output logic                  err,
  output logic [Larid-1:0]      m_arid,
  output logic [Laraddr-1:0]    m_araddr,
  output logic [Llen-1:0]       m_arlen,
  output logic [AXI_SIZE_W-1:0] m_arsize,
  output logic [Lburst-1:0]     m_arburst,
  output logic [Llock-1:0]      m_arlock,
  output logic [Lcache-1:0]     m_arcache,
  output logic [Lprot-1:0]      m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [Larid-1:0]      m_rid,
  input  logic [Lrdata-1:0]     m_rdata,
  input  logic [Lresp-1:0]      m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [Larid-1:0]      m_awid,
  output logic [Laraddr-1:0]    m_awaddr,
  output logic [Llen-1:0]       m_awlen,
  output logic [AXI_SIZE_W-1:0] m_awsize,
  output logic [Lburst-1:0]     m_awburst,
  output logic [Llock-1:0]      m_awlock,
  output logic [Lcache-1:0]     m_awcache,
  output logic [Lprot-1:0]      m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [Larid-1:0]      m_wid,
  output logic [Lrdata-1:0]     m_wdata,
  output logic [Lwstrb-1:0]     m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [Larid-1:0]      m_bid,
  input  logic [Lresp-1:0]      m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B} state_e;

  state_e             state_q, state_d;
  req_payload_t       pl_q, pl_d;
  logic               arvalid_q, arvalid_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               rready_q, rready_d;
  logic               bready_q, bready_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               data_ok_q, data_ok_d;
  logic               err_q, err_d;
  logic [Lrdata-1:0]  rdata_q, rdata_d;
  logic               aw_fin_c, w_fin_c;
  logic               unused_ok;

  // Write-address/data completion including a handshake happening this cycle.
  assign aw_fin_c = aw_done_q | (awvalid_q & m_awready);
  assign w_fin_c  = w_done_q  | (wvalid_q  & m_wready);
  assign addr_ok  = (state_q == S_IDLE) & req;

  always_comb begin
    state_d   = state_q;
    pl_d      = pl_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rready_d  = rready_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    data_ok_d = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          pl_d.addr  = addr;
          pl_d.size  = size;
          pl_d.wdata = wdata;
          pl_d.wstrb = wstrb;
          if (wr) begin
            state_d   = S_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_AR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (m_rvalid) begin
          rready_d  = 1'b0;
          rdata_d   = m_rdata;
          err_d     = (m_rresp != AXI_RESP_OKAY);
          data_ok_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_W: begin
        awvalid_d = awvalid_q & ~m_awready;
        wvalid_d  = wvalid_q & ~m_wready;
        if (aw_fin_c && w_fin_c) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_B;
        end else begin
          aw_done_d = aw_fin_c;
          w_done_d  = w_fin_c;
        end
      end
      S_B: begin
        if (m_bvalid) begin
          bready_d  = 1'b0;
          err_d     = (m_bresp != AXI_RESP_OKAY);
          data_ok_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      pl_q      <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pl_q      <= pl_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rready_q  <= rready_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_ok_q <= data_ok_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_ok   = data_ok_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

  assign m_arid    = ID;
  assign m_araddr  = pl_q.addr;
  assign m_arlen   = '0;
  assign m_arsize  = {1'b0, pl_q.size};
  assign m_arburst = AXI_BURST_INCR;
  assign m_arlock  = '0;
  assign m_arcache = '0;
  assign m_arprot  = '0;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

  assign m_awid    = ID;
  assign m_awaddr  = pl_q.addr;
  assign m_awlen   = '0;
  assign m_awsize  = {1'b0, pl_q.size};
  assign m_awburst = AXI_BURST_INCR;
  assign m_awlock  = '0;
  assign m_awcache = '0;
  assign m_awprot  = '0;
  assign m_awvalid = awvalid_q;

  assign m_wid     = ID;
  assign m_wdata   = pl_q.wdata;
  assign m_wstrb   = pl_q.wstrb;
  assign m_wlast   = 1'b1;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;

  // Response IDs and rlast carry no information for single-beat, single-outstanding traffic.
  assign unused_ok = ^{m_rid, m_rlast, m_bid};

endmodule

// File: tb/tb_sram_axi_master.sv
// Self-checking bench: transaction queue driver plus behavioural AXI slave and memory model.
module tb_sram_axi_master;

  localparam logic [3:0] TB_ID = 4'h5;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;
  logic [3:0]  m_arid, m_awid, m_wid, m_rid, m_bid;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [3:0]  m_arlen, m_awlen, m_arcache, m_awcache, m_wstrb;
  logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
  logic [1:0]  m_arburst, m_awburst, m_arlock, m_awlock, m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;

  always #5 aclk = ~aclk;

  sram_axi_master #(.ID(TB_ID)) dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ard, awd, wdd, rd, bd;
    logic [1:0]  resp;
    int          gap;
  } txn_t;

  txn_t        tq[$];
  int          lat_q[$], awc_q[$], wc_q[$], acc_q[$];
  logic        err_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] smem [256];
  logic [31:0] last_rd = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [1:0] s,
                              input logic [31:0] d, input logic [3:0] st);
    txn_t x;
    x.wr = w; x.addr = a; x.size = s; x.wdata = d; x.wstrb = st;
    x.ard = 0; x.awd = 0; x.wdd = 0; x.rd = 0; x.bd = 0;
    x.resp = 2'b00; x.gap = 0;
    return x;
  endfunction

  task automatic slave_idle();
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_rvalid = 1'b0; m_bvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    m_rid = 4'h0; m_rlast = 1'b0; m_bresp = 2'b00; m_bid = 4'h0;
  endtask

  // Runs every queued transaction; req is held continuously when hold=1.
  task automatic run_queue(input bit hold);
    int n, issue, done_n, t, gap_cnt, t_acc, t_arf, t_last, dok_t;
    int ar_seen, aw_seen, w_seen;
    bit busy, arf, awf, wf, fired, exp_dok;
    txn_t cur;
    logic [31:0] cap_addr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [6:0]  act_c, exp_c;
    logic [53:0] act_p, exp_p;
    logic [40:0] act_w, exp_w;
    n = tq.size(); issue = 0; done_n = 0; t = 0; busy = 0;
    arf = 0; awf = 0; wf = 0; fired = 0; dok_t = -1; t_acc = 0; t_arf = 0; t_last = 0;
    ar_seen = 0; aw_seen = 0; w_seen = 0;
    cap_addr = 32'h0; cap_awaddr = 32'h0; cap_wdata = 32'h0; cap_wstrb = 4'h0;
    gap_cnt = hold ? 0 : tq[0].gap;
    cur = tq[0];
    lat_q.delete(); awc_q.delete(); wc_q.delete(); acc_q.delete(); err_q.delete();
    while (done_n < n && t < 3000) begin
      @(negedge aclk);
      if (issue < n && gap_cnt == 0) begin
        req = 1'b1; wr = tq[issue].wr; addr = tq[issue].addr; size = tq[issue].size;
        wdata = tq[issue].wdata; wstrb = tq[issue].wstrb;
      end else begin
        req = 1'b0; wr = 1'($urandom); addr = $urandom; size = 2'($urandom);
        wdata = $urandom; wstrb = 4'($urandom);
      end
      m_arready = busy && !cur.wr && (ar_seen >= cur.ard);
      m_awready = busy && cur.wr && (aw_seen >= cur.awd);
      m_wready  = busy && cur.wr && (w_seen >= cur.wdd);
      m_rvalid  = busy && !cur.wr && arf && !fired && (t >= t_arf + 1 + cur.rd);
      m_rdata   = m_rvalid ? smem[cap_addr[9:2]] : $urandom;
      m_rresp   = m_rvalid ? cur.resp : 2'($urandom);
      m_rid     = 4'($urandom);
      m_rlast   = 1'($urandom);
      m_bvalid  = busy && cur.wr && awf && wf && !fired && (t >= t_last + 1 + cur.bd);
      m_bresp   = m_bvalid ? cur.resp : 2'($urandom);
      m_bid     = 4'($urandom);
      #1;
      exp_dok  = busy && fired && (t == dok_t);
      exp_c[6] = req && (!busy || exp_dok);
      exp_c[5] = exp_dok;
      exp_c[4] = busy && !cur.wr && (t > t_acc) && !arf;
      exp_c[3] = busy && cur.wr && (t > t_acc) && !awf;
      exp_c[2] = busy && cur.wr && (t > t_acc) && !wf;
      exp_c[1] = busy && !cur.wr && arf && !fired;
      exp_c[0] = busy && cur.wr && awf && wf && !fired;
      act_c = {addr_ok, data_ok, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready};
      n_checks++;
      if (act_c !== exp_c) begin
        n_fail++;
        $display("FAIL ctrl t=%0d {addr_ok,data_ok,arv,awv,wv,rrdy,brdy}: got %b expected %b", t, act_c, exp_c);
      end
      if (exp_c[4]) begin
        act_p = {m_araddr, m_arsize, m_arlen, m_arburst, m_arid, m_arlock, m_arcache, m_arprot};
        exp_p = {cur.addr, 1'b0, cur.size, 4'd0, 2'b01, TB_ID, 2'd0, 4'd0, 3'd0};
        n_checks++;
        if (act_p !== exp_p) begin
          n_fail++;
          $display("FAIL ar_payload t=%0d: got %h expected %h", t, act_p, exp_p);
        end
      end
      if (exp_c[3]) begin
        act_p = {m_awaddr, m_awsize, m_awlen, m_awburst, m_awid, m_awlock, m_awcache, m_awprot};
        exp_p = {cur.addr, 1'b0, cur.size, 4'd0, 2'b01, TB_ID, 2'd0, 4'd0, 3'd0};
        n_checks++;
        if (act_p !== exp_p) begin
          n_fail++;
          $display("FAIL aw_payload t=%0d: got %h expected %h", t, act_p, exp_p);
        end
      end
      if (exp_c[2]) begin
        act_w = {m_wdata, m_wstrb, m_wlast, m_wid};
        exp_w = {cur.wdata, cur.wstrb, 1'b1, TB_ID};
        n_checks++;
        if (act_w !== exp_w) begin
          n_fail++;
          $display("FAIL w_payload t=%0d: got %h expected %h", t, act_w, exp_w);
        end
      end
      if (exp_dok) begin
        if (!cur.wr) last_rd = ref_mem[cur.addr[9:2]];
        n_checks++;
        if (err !== (cur.resp != 2'b00)) begin
          n_fail++;
          $display("FAIL err t=%0d: got %b expected %b", t, err, (cur.resp != 2'b00));
        end
      end
      n_checks++;
      if (rdata !== last_rd) begin
        n_fail++;
        $display("FAIL rdata t=%0d: got %h expected %h", t, rdata, last_rd);
      end
      if (busy && !fired) begin
        if (!cur.wr) begin
          if (arf && m_rvalid && m_rready) begin fired = 1; dok_t = t + 1; end
          if (m_arvalid) ar_seen++;
          if (!arf && m_arvalid && m_arready) begin arf = 1; t_arf = t; cap_addr = m_araddr; end
        end else begin
          if (awf && wf && m_bvalid && m_bready) begin
            fired = 1; dok_t = t + 1;
            for (int b = 0; b < 4; b++)
              if (cap_wstrb[b]) smem[cap_awaddr[9:2]][8*b +: 8] = cap_wdata[8*b +: 8];
          end
          if (m_awvalid) aw_seen++;
          if (m_wvalid) w_seen++;
          if (!awf && m_awvalid && m_awready) begin
            awf = 1; cap_awaddr = m_awaddr; if (t > t_last) t_last = t;
          end
          if (!wf && m_wvalid && m_wready) begin
            wf = 1; cap_wdata = m_wdata; cap_wstrb = m_wstrb; if (t > t_last) t_last = t;
          end
        end
      end
      if (exp_dok) begin
        lat_q.push_back(t - t_acc); awc_q.push_back(aw_seen); wc_q.push_back(w_seen);
        err_q.push_back(err);
        busy = 0; done_n++;
      end
      if (req && addr_ok && !busy && issue < n) begin
        cur = tq[issue]; issue++; busy = 1; t_acc = t; acc_q.push_back(t);
        arf = 0; awf = 0; wf = 0; fired = 0; ar_seen = 0; aw_seen = 0; w_seen = 0; t_last = 0;
        if (cur.wr)
          for (int b = 0; b < 4; b++)
            if (cur.wstrb[b]) ref_mem[cur.addr[9:2]][8*b +: 8] = cur.wdata[8*b +: 8];
        gap_cnt = (hold || issue >= n) ? 0 : tq[issue].gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      t++;
    end
    n_checks++;
    if (done_n < n) begin
      n_fail++;
      $display("FAIL run_timeout: completed %0d of %0d transactions", done_n, n);
    end
    @(negedge aclk);
    req = 1'b0;
    slave_idle();
    #1;
    act_c = {addr_ok, data_ok, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready};
    n_checks++;
    if (act_c !== 7'b0 || rdata !== last_rd) begin
      n_fail++;
      $display("FAIL post_idle: ctrl %b rdata %h expected ctrl 0000000 rdata %h", act_c, rdata, last_rd);
    end
    tq.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    slave_idle();
    repeat (2) @(negedge aclk);
    #1;
    n_checks++;
    if ({addr_ok, data_ok, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, err} !== 8'h0 ||
        rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: ctrl %b err %b rdata %h expected all zero",
               {addr_ok, data_ok, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, err, rdata);
    end
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_read_basic();
    ref_mem[8'h40] = 32'hDEADBEEF; smem[8'h40] = 32'hDEADBEEF;
    tq.push_back(mk(1'b0, 32'h100, 2'd2, 32'h0, 4'h0));
    run_queue(1'b0);
    n_checks++;
    if (lat_q.size() != 1 || lat_q[0] !== 3 || rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_basic: latency %0d rdata %h expected 3 deadbeef",
               lat_q.size() > 0 ? lat_q[0] : -1, rdata);
    end
  endtask

  task automatic test_write_late_aw();
    txn_t x;
    x = mk(1'b1, 32'h204, 2'd2, 32'h12345678, 4'b1100);
    x.awd = 3;
    tq.push_back(x);
    run_queue(1'b0);
    n_checks++;
    if (awc_q.size() != 1 || awc_q[0] !== 4 || wc_q[0] !== 1 || lat_q[0] !== 6) begin
      n_fail++;
      $display("FAIL write_late_aw: awvalid cycles %0d wvalid cycles %0d latency %0d expected 4 1 6",
               awc_q.size() > 0 ? awc_q[0] : -1, wc_q.size() > 0 ? wc_q[0] : -1,
               lat_q.size() > 0 ? lat_q[0] : -1);
    end
    n_checks++;
    if (smem[8'h81][31:16] !== 16'h1234 || smem[8'h81] !== ref_mem[8'h81]) begin
      n_fail++;
      $display("FAIL write_mem: slave word %h expected %h", smem[8'h81], ref_mem[8'h81]);
    end
  endtask

  task automatic test_back_to_back();
    ref_mem[4] = 32'h0; smem[4] = 32'h0;
    tq.push_back(mk(1'b1, 32'h10, 2'd0, 32'h55, 4'b0001));
    tq.push_back(mk(1'b0, 32'h10, 2'd2, 32'h0, 4'h0));
    run_queue(1'b1);
    n_checks++;
    if (acc_q.size() != 2 || acc_q[1] !== acc_q[0] + lat_q[0] || rdata !== 32'h55) begin
      n_fail++;
      $display("FAIL back_to_back: second accept offset %0d rdata %h expected offset %0d rdata 00000055",
               acc_q.size() > 1 ? acc_q[1] - acc_q[0] : -1, rdata, lat_q.size() > 0 ? lat_q[0] : -1);
    end
  endtask

  task automatic test_error();
    txn_t x;
    x = mk(1'b0, 32'h100, 2'd2, 32'h0, 4'h0);
    x.resp = 2'b10;
    tq.push_back(x);
    x = mk(1'b0, 32'h204, 2'd1, 32'h0, 4'h0);
    x.gap = 1;
    tq.push_back(x);
    run_queue(1'b0);
    n_checks++;
    if (err_q.size() != 2 || err_q[0] !== 1'b1 || err_q[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL error_resp: err sequence %0d entries first %b second %b expected 1 0",
               err_q.size(), err_q.size() > 0 ? err_q[0] : 1'bx, err_q.size() > 1 ? err_q[1] : 1'bx);
    end
  endtask

  task automatic test_backpressure();
    txn_t x;
    x = mk(1'b0, 32'h180, 2'd2, 32'h0, 4'h0);
    x.ard = 2; x.rd = 5;
    tq.push_back(x);
    tq.push_back(mk(1'b1, 32'h184, 2'd2, 32'hA5A5_0F0F, 4'b1111));
    run_queue(1'b1);
    n_checks++;
    if (lat_q.size() != 2 || lat_q[0] !== 10 || acc_q[1] !== acc_q[0] + 10) begin
      n_fail++;
      $display("FAIL backpressure: latency %0d second accept offset %0d expected 10 10",
               lat_q.size() > 0 ? lat_q[0] : -1, acc_q.size() > 1 ? acc_q[1] - acc_q[0] : -1);
    end
  endtask

  task automatic test_reset_mid_read();
    txn_t x;
    int t;
    x = mk(1'b0, 32'h100, 2'd2, 32'h0, 4'h0);
    x.resp = 2'b11;
    tq.push_back(x);
    run_queue(1'b0);
    @(negedge aclk);
    req = 1'b1; wr = 1'b0; addr = 32'h300; size = 2'd2; m_arready = 1'b1;
    #1;
    t = 0;
    while (!addr_ok && t < 20) begin @(negedge aclk); #1; t++; end
    @(negedge aclk);
    req = 1'b0;
    #1;
    t = 0;
    while (!m_rready && t < 20) begin @(negedge aclk); #1; t++; end
    n_checks++;
    if (m_rready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_read_enter: rready %b expected 1", m_rready);
    end
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({addr_ok, data_ok, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, err} !== 8'h0 ||
        rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_read_reset: ctrl %b err %b rdata %h expected all zero",
               {addr_ok, data_ok, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, err, rdata);
    end
    @(negedge aclk);
    m_arready = 1'b0;
    aresetn = 1'b1;
    last_rd = 32'h0;
    tq.push_back(mk(1'b0, 32'h100, 2'd2, 32'h0, 4'h0));
    run_queue(1'b0);
    n_checks++;
    if (lat_q.size() != 1 || lat_q[0] !== 3 || rdata !== 32'hDEADBEEF || err !== 1'b0) begin
      n_fail++;
      $display("FAIL read_after_reset: latency %0d rdata %h err %b expected 3 deadbeef 0",
               lat_q.size() > 0 ? lat_q[0] : -1, rdata, err);
    end
  endtask

  task automatic test_random();
    txn_t x;
    logic [31:0] a;
    logic [1:0]  s;
    for (int batch = 0; batch < 4; batch++) begin
      for (int i = 0; i < 10; i++) begin
        s = 2'(int'($urandom_range(0, 2)));
        a = {22'd0, 8'($urandom), 2'b00};
        if (s == 2'd0) a[1:0] = 2'($urandom);
        else if (s == 2'd1) a[1] = 1'($urandom);
        x = mk(1'($urandom), a, s, $urandom, 4'($urandom));
        x.ard = int'($urandom_range(0, 3)); x.awd = int'($urandom_range(0, 3));
        x.wdd = int'($urandom_range(0, 3)); x.rd = int'($urandom_range(0, 3));
        x.bd = int'($urandom_range(0, 3)); x.gap = int'($urandom_range(0, 2));
        x.resp = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'(int'($urandom_range(1, 3)));
        tq.push_back(x);
      end
      run_queue(batch[0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      smem[i] = ref_mem[i];
    end
    test_reset();
    test_read_basic();
    test_write_late_aw();
    test_back_to_back();
    test_error();
    test_backpressure();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_axi_master.md
# sram_axi_master

AXI3 initiator that turns a simple single-request memory port (req/addr_ok/data_ok handshake) into single-beat AXI read or write transactions. It is the initiator-side counterpart of `axi_sram_bridge`. It lets any simple core or DMA engine in the SoC drive the same AXI slave the CPU drives. Exactly one transaction is outstanding at a time.

## Interface
- `ID`, default 0: value driven on `m_arid`, `m_awid` and `m_wid`.
- `aclk`  in  1: clock, rising edge.
- `aresetn`  in  1: reset, asynchronous, active-low.
- `req`  in  1: request valid; held until `addr_ok`.
- `wr`  in  1: 1 = write, 0 = read.
- `size`  in  2: log2 of bytes: 0 = byte, 1 = half, 2 = word.
- `addr`  in  32: byte address; must be aligned to `size`.
- `wdata`  in  32 and `wstrb`  in  4: write data and byte enables.
- `addr_ok`  out  1: request accepted this cycle.
- `data_ok`  out  1: one-cycle pulse that completes a transaction.
- `rdata`  out  32: read data, valid with `data_ok`.
- `err`  out  1: response was not OKAY, valid with `data_ok`.
- `m_arid`/`m_awid`/`m_wid`  out  4: `ID`.
- `m_araddr`/`m_awaddr`  out  32: registered `addr`.
- `m_arlen`/`m_awlen`  out  4: 0.
- `m_arsize`/`m_awsize`  out  3: {0, `size`}.
- `m_arburst`/`m_awburst`  out  2: 2'b01 (INCR).
- `m_arlock`/`m_awlock`  out  2, `m_arcache`/`m_awcache`  out  4, `m_arprot`/`m_awprot`  out  3: all 0.
- `m_arvalid`  out  1 and `m_arready`  in  1: read-address handshake.
- `m_rid`  in  4, `m_rdata`  in  32, `m_rresp`  in  2, `m_rlast`  in  1, `m_rvalid`  in  1, `m_rready`  out  1: read-data channel.
- `m_awvalid`  out  1 and `m_awready`  in  1: write-address handshake.
- `m_wdata`  out  32, `m_wstrb`  out  4, `m_wlast`  out  1 (constant 1), `m_wvalid`  out  1, `m_wready`  in  1: write-data channel.
- `m_bid`  in  4, `m_bresp`  in  2, `m_bvalid`  in  1, `m_bready`  out  1: write-response channel.

## Operation
- FSM states: IDLE, AR, R, W, B.
- IDLE:
  - `addr_ok = req` (combinational).
  - On accept, register `addr`, `size`, `wdata`, `wstrb`.
  - Next state is AR if `wr`=0, else W.
- AR:
  - `m_arvalid`=1 until `m_arready`, then go to R.
- R:
  - `m_rready`=1.
  - On the first `m_rvalid`, capture `m_rdata` into `rdata` and set `err = (m_rresp != 0)`, then go to IDLE.
  - `m_rlast` and `m_rid` are ignored.
- W:
  - `m_awvalid` and `m_wvalid` are both raised on entry.
  - Each deasserts independently after its own handshake.
  - Two sticky flags record AW done and W done.
  - When both flags are set (including same-cycle handshakes), go to B.
- B:
  - `m_bready`=1.
  - On `m_bvalid`, set `err = (m_bresp != 0)` and go to IDLE.
  - `m_bid` is ignored.
- `data_ok` is registered: high for exactly one cycle, the cycle after the R or B handshake.
- `rdata` holds its value until the next read completes.
- `req` is not sampled outside IDLE. A misaligned `addr` is forwarded unchanged; the slave defines the result.

## Timing
- Reset values (async assert): state IDLE, every `m_*valid`=0, `m_rready`=`m_bready`=0, `data_ok`=0, `err`=0, `rdata`=0, flags cleared.
- Best-case read, with `addr_ok` at cycle T and a zero-wait slave:
  - `m_arvalid` at T+1.
  - R handshake at T+2.
  - `data_ok` at T+3.
- Best-case write: AW and W both accepted at T+1, B at T+2, `data_ok` at T+3.
- Each valid stays asserted, with stable payload, until its ready arrives. Valid never depends on ready.
- The FSM is back in IDLE in the `data_ok` cycle, so a back-to-back `addr_ok` may occur in that same cycle.
- Reset mid-transaction abandons the transaction. The whole SoC shares `aresetn`, so the slave resets too.

## Structure
- Shared defines (existing AXI width header): `Larid`, `Laraddr`, `Lrdata` and related widths.
- New shared constants: `AXI_BURST_INCR`=2'b01, `AXI_RESP_OKAY`=2'b00, `AXI_SIZE_W`=3.
- FSM state encoding is local to the module.
- Single flat module; no sub-module.

## Test plan
- Read, zero-wait slave: `addr`=0x100, `size`=2, slave returns 0xDEADBEEF → `m_araddr`=0x100, `m_arsize`=2, `data_ok` at T+3, `rdata`=0xDEADBEEF, `err`=0.
- Write with `m_awready` 3 cycles late and `m_wready` immediate: `addr`=0x204, `wdata`=0x12345678, `wstrb`=4'b1100 → `m_wvalid` drops after 1 cycle, `m_awvalid` holds 4 cycles, B is taken only after both, then one `data_ok`.
- Back-to-back: write 0x55 to 0x10 then read 0x10 through the SRAM bridge → second `addr_ok` in the first `data_ok` cycle, read returns 0x55.
- Error responses: `m_rresp`=2'b10 → `err`=1 with `data_ok`; a following OKAY read → `err`=0.
- Reset mid-read: `aresetn` low while in R → all outputs return to reset values immediately; after release, a new read completes normally.
- Backpressure: `m_rvalid` delayed 5 cycles while `req` is held high → no second `addr_ok` before `data_ok`; `m_araddr` stays stable throughout AR.
